// File: rtl/uart_rx_engine.sv
// -----------------------------------------------------------------------------
// uart_rx_engine
//
// Serial receive end of the UART link. The asynchronous line is brought into
// the clock domain through a two-flop synchroniser, a falling edge on the
// synchronised line starts a frame, and every bit is sampled once at its
// centre. Frames carry 5..8 data bits (LSB first), optional odd/even parity
// and one or two stop bits. Each received byte is presented for exactly one
// cycle together with its parity and framing error flags.
//
// Parameters
//   P_CLK_DIV          clock cycles per bit period (4..65535)
//   P_USER_DATA_WIDTH  width of the delivered data word (fixed at 8)
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   i_uart_rx        in   serial line, asynchronous, idles high
//   i_data_bits      in   data bits per frame (5..8, anything else means 8)
//   i_stop_bits      in   2 selects two stop bits, anything else one
//   i_check_bits     in   0/3 no parity, 1 odd, 2 even
//   o_user_rx_data   out  received data, right-aligned, unused upper bits 0
//   o_user_rx_valid  out  one-cycle pulse: data and flags are valid
//   o_parity_err     out  parity mismatch of the delivered frame
//   o_frame_err      out  a stop bit of the delivered frame was sampled low
//   o_rx_busy        out  high from start detection until return to idle
// -----------------------------------------------------------------------------
module uart_rx_engine #(
    parameter int P_CLK_DIV         = 434,
    parameter int P_USER_DATA_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_uart_rx,
    input  logic [3:0]                   i_data_bits,
    input  logic [1:0]                   i_stop_bits,
    input  logic [1:0]                   i_check_bits,
    output logic [P_USER_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_parity_err,
    output logic                         o_frame_err,
    output logic                         o_rx_busy
);

    localparam int CW = (P_CLK_DIV > 2) ? $clog2(P_CLK_DIV) : 2;
    localparam logic [CW-1:0] CNT_MAX    = CW'(P_CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(P_CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Returns 1 when the data ones plus the parity bit break the selected rule.
    function automatic logic parity_mismatch(
        input logic [P_USER_DATA_WIDTH-1:0] data,
        input logic                         pbit,
        input logic                         odd
    );
        logic total_odd;
        total_odd = ^{data, pbit};
        return odd ? ~total_odd : total_odd;
    endfunction

    // Synchroniser and edge-detect history
    logic sync1_q;
    logic rx_s_q;
    logic rx_prev_q;

    // Control
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          stop_idx_q, stop_idx_d;

    // Configuration latched at start detection
    logic [3:0] nbits_q, nbits_d;
    logic       two_stop_q, two_stop_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;

    // Frame accumulation
    logic [P_USER_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                         perr_acc_q, perr_acc_d;
    logic                         ferr_acc_q, ferr_acc_d;

    // Registered outputs
    logic [P_USER_DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         perr_q, perr_d;
    logic                         ferr_q, ferr_d;
    logic                         busy_q, busy_d;

    logic start_edge_s;
    logic sample_s;
    logic last_data_s;
    logic last_stop_s;

    assign start_edge_s = rx_prev_q & ~rx_s_q;
    // The counter runs freely through the frame, so after the start-bit
    // centre every later sample lands exactly one bit period further on.
    assign sample_s     = (cnt_q == CNT_SAMPLE);
    assign last_data_s  = (bit_cnt_q == (nbits_q - 4'd1));
    assign last_stop_s  = (stop_idx_q == two_stop_q);

    // Two-flop synchroniser plus previous-sample register; preset to idle-high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (sample_s) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (sample_s && last_data_s) begin
                    if (par_en_q) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (sample_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                // Leave at the centre of the last stop bit so a following
                // start edge without idle gap is still seen in IDLE.
                if (sample_s && last_stop_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output and datapath next-state logic
    always_comb begin
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        nbits_d    = nbits_q;
        two_stop_d = two_stop_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        busy_d     = (state_d != S_IDLE);

        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    if ((i_data_bits >= 4'd5) && (i_data_bits <= 4'd8)) begin
                        nbits_d = i_data_bits;
                    end else begin
                        nbits_d = 4'd8;
                    end
                    two_stop_d = (i_stop_bits == 2'd2);
                    par_en_d   = (i_check_bits == 2'd1) || (i_check_bits == 2'd2);
                    par_odd_d  = (i_check_bits == 2'd1);
                    shift_d    = '0;
                    bit_cnt_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_DATA: begin
                // Writing at the bit index keeps short words right-aligned.
                if (sample_s) begin
                    shift_d[bit_cnt_q[2:0]] = rx_s_q;
                    bit_cnt_d               = bit_cnt_q + 4'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            S_PARITY: begin
                if (sample_s) begin
                    perr_acc_d = parity_mismatch(shift_q, rx_s_q, par_odd_q);
                end else begin
                    perr_acc_d = perr_acc_q;
                end
            end
            S_STOP: begin
                if (sample_s) begin
                    ferr_acc_d = ferr_acc_q | ~rx_s_q;
                    stop_idx_d = 1'b1;
                    if (last_stop_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = perr_acc_q;
                        ferr_d  = ferr_acc_q | ~rx_s_q;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    stop_idx_d = stop_idx_q;
                end
            end
            default: begin
                bit_cnt_d = bit_cnt_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            bit_cnt_q  <= 4'd0;
            stop_idx_q <= 1'b0;
            nbits_q    <= 4'd8;
            two_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            nbits_q    <= nbits_d;
            two_stop_q <= two_stop_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_parity_err    = perr_q;
    assign o_frame_err     = ferr_q;
    assign o_rx_busy       = busy_q;

endmodule
